// File: rtl/acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : acq_sequencer
// Brief    : ADC setup sequencer, multi-channel sample packer and block-ready flag
// Revision : 1.0 - initial release
// ============================================================================
module acq_sequencer #(
    parameter int NUM_CH       = 2,
    parameter int SAMPLE_WIDTH = 32,
    parameter int BLOCKSIZE    = 8192,
    parameter int WRCNT_WIDTH  = 12,
    parameter int LDCTRL_DELAY = 100,
    parameter int SETTLE_DELAY = 900
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic [NUM_CH-1:0]              ch_valid,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] ch_data,
    output logic                           ldctrl,
    output logic                           agc_load,
    output logic                           adc_enable,
    output logic [NUM_CH*SAMPLE_WIDTH-1:0] fifo_wdata,
    output logic                           fifo_we,
    input  logic                           fifo_full,
    input  logic [WRCNT_WIDTH-1:0]         fifo_wrcnt,
    output logic                           blk_rdy,
    output logic                           skew_err,
    output logic                           ovf_err,
    input  logic                           err_clr,
    output logic [1:0]                     state,
    output logic [31:0]                    word_cnt
);

    localparam int c_dw      = NUM_CH * SAMPLE_WIDTH;
    localparam int c_max_dly = (LDCTRL_DELAY > SETTLE_DELAY) ? LDCTRL_DELAY : SETTLE_DELAY;
    localparam int c_cnt_w   = $clog2(c_max_dly + 1);
    localparam int c_mul_w   = WRCNT_WIDTH + 16;

    localparam logic [c_cnt_w-1:0] c_ld_last     = c_cnt_w'(LDCTRL_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_st_last     = c_cnt_w'(SETTLE_DELAY - 1);
    localparam logic [c_mul_w-1:0] c_word_bytes  = c_mul_w'(c_dw / 8);
    localparam logic [c_mul_w-1:0] c_block_bytes = c_mul_w'(BLOCKSIZE);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_load   = 2'd1;
    localparam logic [1:0] c_settle = 2'd2;
    localparam logic [1:0] c_run    = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_ld_hit;
    logic               w_st_hit;

    logic               w_ldctrl_nxt;
    logic               w_en_nxt;
    logic               w_pack;
    logic               w_clear;
    logic               w_start;

    logic [NUM_CH-1:0]  r_pend;
    logic [c_dw-1:0]    r_hold;
    logic [NUM_CH-1:0]  w_vmask;
    logic [NUM_CH-1:0]  w_pend_any;
    logic [c_dw-1:0]    w_merged;
    logic               w_complete;
    logic               w_skew_evt;
    logic               w_ovf_evt;
    logic               w_write;
    logic [c_mul_w-1:0] w_bytes;

    logic               r_ldctrl;
    logic               r_agc_load;
    logic               r_adc_enable;
    logic [c_dw-1:0]    r_wdata;
    logic               r_we;
    logic               r_blk_rdy;
    logic               r_skew_err;
    logic               r_ovf_err;
    logic [31:0]        r_word_cnt;

    assign w_ld_hit = (r_state == c_load)   && (r_cnt == c_ld_last);
    assign w_st_hit = (r_state == c_settle) && (r_cnt == c_st_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; stop outranks start and delay expiry
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:   if (start && !stop) w_next = c_load;
            c_load:   if (stop) w_next = c_idle; else if (w_ld_hit) w_next = c_settle;
            c_settle: if (stop) w_next = c_idle; else if (w_st_hit) w_next = c_run;
            c_run:    if (stop) w_next = c_idle;
            default:  w_next = c_idle;
        endcase
    end

    // Output decode: values that the output registers take at the next edge
    always_comb begin
        w_ldctrl_nxt = w_ld_hit && !stop;
        w_en_nxt     = (r_state == c_run) && (w_next == c_run);
        w_pack       = (r_state == c_run) && !stop;
        w_clear      = stop && (r_state != c_idle);
        w_start      = (r_state == c_idle) && start && !stop;
    end

    // Merge holding registers with strobes arriving this cycle
    always_comb begin
        w_vmask    = w_pack ? ch_valid : '0;
        w_pend_any = r_pend | w_vmask;
        w_complete = w_pack && (&w_pend_any);
        w_skew_evt = (|(w_vmask & r_pend)) && !w_complete;
        w_ovf_evt  = w_complete && fifo_full;
        w_write    = w_complete && !fifo_full;
        w_merged   = r_hold;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_vmask[k]) begin
                w_merged[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = ch_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
        w_bytes = {16'd0, fifo_wrcnt} * c_word_bytes;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_ldctrl     <= 1'b0;
            r_agc_load   <= 1'b0;
            r_adc_enable <= 1'b0;
            r_pend       <= '0;
            r_hold       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_blk_rdy    <= 1'b0;
            r_skew_err   <= 1'b0;
            r_ovf_err    <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            // Counter runs only while dwelling in LOAD or SETTLE
            if ((w_next == r_state) && ((r_state == c_load) || (r_state == c_settle))) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            r_ldctrl     <= w_ldctrl_nxt;
            r_agc_load   <= w_ldctrl_nxt;
            r_adc_enable <= w_en_nxt;

            if (w_clear) begin
                r_pend <= '0;
                r_hold <= '0;
            end else begin
                r_pend <= w_complete ? '0 : w_pend_any;
                r_hold <= w_merged;
            end

            r_we <= w_write;
            if (w_write) begin
                r_wdata <= w_merged;
            end

            if (w_start) begin
                r_word_cnt <= '0;
            end else if (w_write) begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end

            r_skew_err <= (r_skew_err && !err_clr) || w_skew_evt;
            r_ovf_err  <= (r_ovf_err  && !err_clr) || w_ovf_evt;
            r_blk_rdy  <= (w_bytes >= c_block_bytes);
        end
    end

    assign state      = r_state;
    assign ldctrl     = r_ldctrl;
    assign agc_load   = r_agc_load;
    assign adc_enable = r_adc_enable;
    assign fifo_wdata = r_wdata;
    assign fifo_we    = r_we;
    assign blk_rdy    = r_blk_rdy;
    assign skew_err   = r_skew_err;
    assign ovf_err    = r_ovf_err;
    assign word_cnt   = r_word_cnt;

endmodule
`default_nettype wire
